// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register pending-write scoreboard for decode-stage hazard detection.
//
// Handshake: there is no valid/ready pair here. Every input is sampled on
// each rising edge and has an effect only when its qualifier (wen[w] or
// iss_valid) is high; reads are combinational and never stall.
module regfile_mp_sb #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int NWR      = 1,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_conflict
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Register writes; ports are visited in ascending order so the highest
  // index port wins when several target the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wen[w] && !(ZERO_REG != 0 && waddr[w*AW +: AW] == '0))
          regs[waddr[w*AW +: AW]] <= wdata[w*XLEN +: XLEN];
      end
    end
  end

  // Next scoreboard state: writebacks clear, a new issue sets, and the set is
  // applied last so a fresh writer to the same register keeps it pending.
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NWR; w++) begin
      if (wen[w]) busy_nxt[waddr[w*AW +: AW]] = 1'b0;
    end
    if (iss_valid) busy_nxt[iss_rd] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Read ports: array lookup, then same-cycle forwarding, then the hardwired
  // zero register which overrides everything. Held at zero during reset.
  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;
    rdata = '0;
    rbusy = '0;
    a     = '0;
    d     = '0;
    b     = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      a = raddr[i*AW +: AW];
      d = regs[a];
      b = busy[a];
      if (BYPASS != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (wen[w] && waddr[w*AW +: AW] == a) begin
            d = wdata[w*XLEN +: XLEN];
            b = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0 && a == '0) || rst) begin
        d = '0;
        b = 1'b0;
      end
      rdata[i*XLEN +: XLEN] = d;
      rbusy[i]              = b;
    end
  end

  // WAW diagnostic uses the registered scoreboard, not the forwarded view.
  always_comb begin
    iss_conflict = iss_valid && busy[iss_rd] && !rst;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: two instances share stimulus.
//   dut_a: NWR=2, BYPASS=1   dut_b: NWR=1 (port 0 only), BYPASS=0
// A behavioural model of both register files is checked on every falling
// edge, and directed steps pin literal values from hand calculation.
module tb_regfile_mp_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0]   raddr;
  logic [1:0]          wen;
  logic [2*AW-1:0]     waddr;
  logic [2*XLEN-1:0]   wdata;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;

  logic [NRD*XLEN-1:0] rdata_a, rdata_b;
  logic [NRD-1:0]      rbusy_a, rbusy_b;
  logic                conf_a, conf_b;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(2),
                  .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_conflict(conf_a));

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(1),
                  .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .wen(wen[0:0]), .waddr(waddr[AW-1:0]), .wdata(wdata[XLEN-1:0]),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_conflict(conf_b));

  // ---------------- scoreboard / model ----------------
  int   n_tests = 0;
  int   n_fail  = 0;
  logic started = 1'b0;

  logic [XLEN-1:0] m_reg  [2][NREGS];
  logic            m_busy [2][NREGS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nwr_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Expected {busy, data} seen on a read of address a by instance k.
  function automatic logic [XLEN:0] exp_read(input int k, input logic [AW-1:0] a);
    logic [XLEN:0] res;
    if (rst || a == 0) return '0;
    res = {m_busy[k][a], m_reg[k][a]};
    if (k == 0) begin
      for (int w = 0; w < nwr_of(k); w++)
        if (wen[w] && waddr[w*AW +: AW] == a) res = {1'b0, wdata[w*XLEN +: XLEN]};
    end
    return res;
  endfunction

  // Model state update: architectural effect of one clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < NREGS; r++) begin
          m_reg[k][r]  <= '0;
          m_busy[k][r] <= 1'b0;
        end
    end else begin
      for (int k = 0; k < 2; k++)
        for (int r = 1; r < NREGS; r++) begin
          for (int w = 0; w < nwr_of(k); w++)
            if (wen[w] && waddr[w*AW +: AW] == r) begin
              m_reg[k][r]  <= wdata[w*XLEN +: XLEN];
              m_busy[k][r] <= 1'b0;
            end
          if (iss_valid && iss_rd == r) m_busy[k][r] <= 1'b1;
        end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < NRD; i++) begin
          logic [XLEN:0] e;
          e = exp_read(k, raddr[i*AW +: AW]);
          check($sformatf("model_rdata_%0d[%0d]", k, i),
                (k == 0) ? rdata_a[i*XLEN +: XLEN] : rdata_b[i*XLEN +: XLEN], e[XLEN-1:0]);
          check($sformatf("model_rbusy_%0d[%0d]", k, i),
                {31'd0, (k == 0) ? rbusy_a[i] : rbusy_b[i]}, {31'd0, e[XLEN]});
        end
        check($sformatf("model_conflict_%0d", k), {31'd0, (k == 0) ? conf_a : conf_b},
              {31'd0, !rst && iss_valid && m_busy[k][iss_rd]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    wen       = '0;
    waddr     = '0;
    wdata     = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    idle();
    raddr = '0;
    rst   = 1'b1;
    started = 1'b1;
    repeat (2) tick();
    settle();
    check("reset_rdata", rdata_a[31:0], 32'h0);
    tick();
    rst = 1'b0;

    // write r3, read it next cycle
    wen = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h12345678};
    tick();
    idle(); raddr = {5'd0, 5'd3};
    settle();
    check("wr_rd_a", rdata_a[31:0], 32'h12345678);
    check("wr_rd_b", rdata_b[31:0], 32'h12345678);
    check("wr_rd_busy", {31'd0, rbusy_a[0]}, 32'h0);
    tick();

    // same-cycle bypass on read port 1
    wen = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'hA5A5A5A5};
    raddr = {5'd7, 5'd3};
    settle();
    check("bypass_a", rdata_a[63:32], 32'hA5A5A5A5);
    check("nobypass_b_old", rdata_b[63:32], 32'h0);
    tick();
    idle();
    settle();
    check("nobypass_b_new", rdata_b[63:32], 32'hA5A5A5A5);
    tick();

    // zero register
    wen = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFFFFFF};
    iss_valid = 1'b1; iss_rd = 5'd0; raddr = {5'd0, 5'd0};
    settle();
    check("zero_rdata", rdata_a[31:0], 32'h0);
    check("zero_rbusy", {31'd0, rbusy_a[0]}, 32'h0);
    check("zero_conflict", {31'd0, conf_a}, 32'h0);
    tick();
    idle();
    settle();
    check("zero_rdata_after", rdata_a[31:0], 32'h0);
    check("zero_rbusy_after", {31'd0, rbusy_b[0]}, 32'h0);
    tick();

    // scoreboard on r9
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    idle(); raddr = {5'd0, 5'd9};
    repeat (3) tick();
    settle();
    check("sb_busy_a", {31'd0, rbusy_a[0]}, 32'h1);
    check("sb_busy_b", {31'd0, rbusy_b[0]}, 32'h1);
    tick();
    wen = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h99};
    iss_valid = 1'b1; iss_rd = 5'd9;
    settle();
    check("sb_fwd_busy_a", {31'd0, rbusy_a[0]}, 32'h0);
    check("sb_fwd_busy_b", {31'd0, rbusy_b[0]}, 32'h1);
    tick();
    wen = '0;
    settle();
    check("sb_still_busy", {31'd0, rbusy_a[0]}, 32'h1);
    check("sb_conflict_a", {31'd0, conf_a}, 32'h1);
    check("sb_conflict_b", {31'd0, conf_b}, 32'h1);
    tick();
    idle();

    // dual write to r4: port 1 wins
    wen = 2'b11; waddr = {5'd4, 5'd4}; wdata = {32'h2, 32'h1}; raddr = {5'd0, 5'd4};
    settle();
    check("dual_bypass_a", rdata_a[31:0], 32'h2);
    check("dual_old_b", rdata_b[31:0], 32'h0);
    tick();
    idle();
    settle();
    check("dual_a", rdata_a[31:0], 32'h2);
    check("dual_b", rdata_b[31:0], 32'h1);
    tick();

    // reset mid-run after writing and issuing r5
    wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    idle(); raddr = {5'd0, 5'd5};
    settle();
    check("pre_rst_data", rdata_a[31:0], 32'hDEADBEEF);
    check("pre_rst_busy", {31'd0, rbusy_a[0]}, 32'h1);
    rst = 1'b1;
    #1;
    check("in_rst_data", rdata_a[31:0], 32'h0);
    check("in_rst_busy", {31'd0, rbusy_a[0]}, 32'h0);
    tick();
    rst = 1'b0;
    settle();
    check("post_rst_data_a", rdata_a[31:0], 32'h0);
    check("post_rst_data_b", rdata_b[31:0], 32'h0);
    check("post_rst_busy", {31'd0, rbusy_a[0]}, 32'h0);
    tick();

    // randomized traffic, checked by the per-cycle model compare
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 149) == 0);
      wen       = 2'($urandom_range(0, 3));
      waddr     = {rand_addr(), rand_addr()};
      wdata     = {$urandom, $urandom};
      raddr     = {rand_addr(), rand_addr()};
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = rand_addr();
      tick();
    end
    rst = 1'b0;
    idle();
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
